// File: rtl/alu_4bit.sv
// Registered 4-bit ALU with carry/zero/negative/overflow flags and a VALID
// indicator; one-cycle latency, one operation per clock.
module alu_4bit (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] OPCODE,
    input  logic [3:0] OP1,
    input  logic [3:0] OP2,
    output logic [3:0] RESULT,
    output logic       CARRY,
    output logic       ZERO,
    output logic       NEG,
    output logic       OVF,
    output logic       VALID
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_t;

    op_t        op;
    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] res_next;
    logic       carry_next;
    logic       ovf_next;

    assign op   = op_t'(OPCODE);
    assign sum  = {1'b0, OP1} + {1'b0, OP2};
    // The fifth bit of the widened difference is the unsigned borrow.
    assign diff = {1'b0, OP1} - {1'b0, OP2};

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_next   = sum[3:0];
                carry_next = sum[4];
                ovf_next   = (OP1[3] == OP2[3]) && (sum[3] != OP1[3]);
            end
            OP_SUB: begin
                res_next   = diff[3:0];
                carry_next = diff[4];
                ovf_next   = (OP1[3] != OP2[3]) && (diff[3] != OP1[3]);
            end
            OP_AND: res_next = OP1 & OP2;
            OP_OR:  res_next = OP1 | OP2;
            OP_XOR: res_next = OP1 ^ OP2;
            OP_NOT: res_next = ~OP1;
            OP_SHL: begin
                res_next   = {OP1[2:0], 1'b0};
                carry_next = OP1[3];
            end
            OP_SHR: begin
                res_next   = {1'b0, OP1[3:1]};
                carry_next = OP1[0];
            end
            default: begin
                res_next   = '0;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
        endcase
    end

    // ZERO deliberately reads 0 in reset, so it is registered rather than
    // decoded from RESULT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RESULT <= '0;
            CARRY  <= 1'b0;
            ZERO   <= 1'b0;
            NEG    <= 1'b0;
            OVF    <= 1'b0;
            VALID  <= 1'b0;
        end else begin
            RESULT <= res_next;
            CARRY  <= carry_next;
            ZERO   <= (res_next == 4'b0000);
            NEG    <= res_next[3];
            OVF    <= ovf_next;
            VALID  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: arithmetic reference model, per-cycle
// compare process, directed literal checks and randomized stimulus.
module tb_alu_4bit;

    logic       clk;
    logic       rstn;
    logic [2:0] OPCODE;
    logic [3:0] OP1;
    logic [3:0] OP2;
    logic [3:0] RESULT;
    logic       CARRY;
    logic       ZERO;
    logic       NEG;
    logic       OVF;
    logic       VALID;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Expected outputs packed as {result, carry, zero, neg, ovf, valid}.
    logic [8:0] exp_out;

    alu_4bit dut (
        .clk    (clk),
        .rstn   (rstn),
        .OPCODE (OPCODE),
        .OP1    (OP1),
        .OP2    (OP2),
        .RESULT (RESULT),
        .CARRY  (CARRY),
        .ZERO   (ZERO),
        .NEG    (NEG),
        .OVF    (OVF),
        .VALID  (VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Reference: operands treated as plain integers, results reduced mod 16.
    function automatic logic [8:0] model(input int op, input int a, input int b);
        int r, c, o, s;
        r = 0; c = 0; o = 0;
        case (op)
            0: begin
                r = (a + b) % 16;
                c = (a + b > 15) ? 1 : 0;
                s = to_signed4(a) + to_signed4(b);
                o = (s > 7 || s < -8) ? 1 : 0;
            end
            1: begin
                r = (a - b + 16) % 16;
                c = (a < b) ? 1 : 0;
                s = to_signed4(a) - to_signed4(b);
                o = (s > 7 || s < -8) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
            7: begin r = a / 2;        c = a % 2;            end
            default: r = 0;
        endcase
        return {4'(r), 1'(c), (r == 0) ? 1'b1 : 1'b0, (r >= 8) ? 1'b1 : 1'b0, 1'(o), 1'b1};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) exp_out = '0;
        else       exp_out = model(int'(OPCODE), int'(OP1), int'(OP2));
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({RESULT, CARRY, ZERO, NEG, OVF, VALID} !== exp_out) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got=%b required=%b", $time,
                         {RESULT, CARRY, ZERO, NEG, OVF, VALID}, exp_out);
            end
        end
    end

    task automatic check_lit(input string name, input logic [3:0] r, input logic c,
                             input logic z, input logic n, input logic o, input logic v);
        checks++;
        if ({RESULT, CARRY, ZERO, NEG, OVF, VALID} !== {r, c, z, n, o, v}) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name,
                     {RESULT, CARRY, ZERO, NEG, OVF, VALID}, {r, c, z, n, o, v});
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        #1;
        OPCODE = op; OP1 = a; OP2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            OPCODE = 3'($urandom_range(7, 0));
            OP1    = 4'($urandom_range(15, 0));
            OP2    = 4'($urandom_range(15, 0));
        end
    endtask

    initial begin
        rstn = 1'b1;
        OPCODE = 3'b000; OP1 = 4'b1010; OP2 = 4'b1010;
        #1;
        rstn = 1'b0;
        #1;
        cmp_en = 1;
        check_lit("reset_async", 4'b0000, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_hold", 4'b0000, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_lit("reset_release_add", 4'b0100, 1, 0, 0, 1, 1);

        apply(3'b000, 4'b0111, 4'b0001); check_lit("add_ovf",  4'b1000, 0, 0, 1, 1, 1);
        apply(3'b001, 4'b0011, 4'b0101); check_lit("sub_borrow", 4'b1110, 1, 0, 1, 0, 1);
        apply(3'b001, 4'b0110, 4'b0110); check_lit("sub_zero", 4'b0000, 0, 1, 0, 0, 1);
        apply(3'b001, 4'b1000, 4'b0001); check_lit("sub_ovf",  4'b0111, 0, 0, 0, 1, 1);
        apply(3'b000, 4'b1111, 4'b0001); check_lit("add_carry_zero", 4'b0000, 1, 1, 0, 0, 1);
        apply(3'b010, 4'b1100, 4'b1010); check_lit("and",      4'b1000, 0, 0, 1, 0, 1);
        apply(3'b011, 4'b1100, 4'b1010); check_lit("or",       4'b1110, 0, 0, 1, 0, 1);
        apply(3'b100, 4'b1100, 4'b1010); check_lit("xor",      4'b0110, 0, 0, 0, 0, 1);
        apply(3'b101, 4'b1100, 4'b1010); check_lit("not",      4'b0011, 0, 0, 0, 0, 1);
        apply(3'b110, 4'b1001, 4'b0000); check_lit("shl",      4'b0010, 1, 0, 0, 0, 1);
        apply(3'b111, 4'b1001, 4'b0000); check_lit("shr",      4'b0100, 1, 0, 0, 0, 1);
        apply(3'b110, 4'b0000, 4'b1111); check_lit("shl_zero", 4'b0000, 0, 1, 0, 0, 1);
        apply(3'b111, 4'b0000, 4'b1111); check_lit("shr_zero", 4'b0000, 0, 1, 0, 0, 1);

        random_ops(300);

        for (int i = 0; i < 4; i++) begin
            apply(3'b000, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        end
        apply(3'b000, 4'b1111, 4'b1111);
        check_lit("add_before_reset", 4'b1110, 1, 0, 1, 0, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_lit("reset_mid_cycle", 4'b0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_lit("reset_mid_hold", 4'b0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rstn = 1'b1;

        random_ops(200);
        @(negedge clk);
        #1;
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
